// File: rtl/bridge_req_arbiter_pkg.sv
// Shared types and helpers for the DRAM bridge request arbiter.
package bridge_req_arbiter_pkg;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_WAIT  = 2'd2,
    A_RESP  = 2'd3
  } arb_state;

  localparam int MAX_REQ = 4;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  logic [NUM_REQ-1:0] upper_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign upper_req[gi] = req[gi] && (ID_W'(gi) >= rr_ptr);
      assign grant[gi]     = req[gi] && (id == ID_W'(gi));
    end
  endgenerate

  // Lowest request at/after the pointer wins; otherwise wrap to the lowest request overall.
  always_comb begin
    id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
    if (|upper_req) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (upper_req[i]) id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/bridge_req_arbiter.sv
// Round-robin sharing of the single DRAM bridge command port between NUM_REQ requesters.
module bridge_req_arbiter
  import bridge_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_r_wb,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_w,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data_r,
  output logic                      busy,
  output logic                      proto_err,
  output logic                      C_in_valid,
  output logic                      C_r_wb,
  output logic [ADDR_W-1:0]         C_addr,
  output logic [DATA_W-1:0]         C_data_w,
  input  logic                      C_out_valid,
  input  logic [DATA_W-1:0]         C_data_r
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state            state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [ID_W-1:0]     id_reg;
  logic                c_r_wb_reg;
  logic [ADDR_W-1:0]   c_addr_reg;
  logic [DATA_W-1:0]   c_data_w_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                proto_err_reg;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;
  logic [ID_W-1:0]     rr_ptr_next;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi]  = req_data_w[gi*DATA_W +: DATA_W];
      assign req_grant[gi] = (state_reg == A_ISSUE) && (id_reg == ID_W'(gi));
      assign rsp_valid[gi] = (state_reg == A_RESP) && (id_reg == ID_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .grant  (arb_grant),
    .id     (arb_id)
  );

  assign arb_any     = |arb_grant;
  assign rr_ptr_next = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      A_IDLE:  if (arb_any) state_next = A_ISSUE;
      A_ISSUE: state_next = A_WAIT;
      A_WAIT:  if (C_out_valid) state_next = A_RESP;
      A_RESP:  state_next = A_IDLE;
      default: state_next = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= A_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Command regs are loaded only on acceptance, so they hold through the whole transaction
  // and keep their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      c_r_wb_reg    <= 1'b0;
      c_addr_reg    <= '0;
      c_data_w_reg  <= '0;
      rsp_data_reg  <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (C_out_valid && (state_reg != A_WAIT)) proto_err_reg <= 1'b1;
      case (state_reg)
        A_IDLE: begin
          if (arb_any) begin
            id_reg       <= arb_id;
            c_r_wb_reg   <= req_r_wb[arb_id];
            c_addr_reg   <= addr_arr[arb_id];
            c_data_w_reg <= data_arr[arb_id];
          end
        end
        A_ISSUE: rr_ptr_reg <= rr_ptr_next;
        A_WAIT: begin
          if (C_out_valid) rsp_data_reg <= c_r_wb_reg ? C_data_r : '0;
        end
        A_RESP: rsp_data_reg <= '0;
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != A_IDLE);
  assign proto_err  = proto_err_reg;
  assign C_in_valid = (state_reg == A_ISSUE);
  assign C_r_wb     = c_r_wb_reg;
  assign C_addr     = c_addr_reg;
  assign C_data_w   = c_data_w_reg;
  assign rsp_data_r = rsp_data_reg;

endmodule

// File: tb/tb_bridge_req_arbiter.sv
// Bench for bridge_req_arbiter: random-latency bridge/DRAM model plus a round-robin reference model.
module tb_bridge_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_r_wb = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data_w = '0;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data_r;
  logic            busy;
  logic            proto_err;
  logic            C_in_valid;
  logic            C_r_wb;
  logic [AW-1:0]   C_addr;
  logic [DW-1:0]   C_data_w;
  logic            C_out_valid;
  logic [DW-1:0]   C_data_r;

  logic            br_ov = 1'b0;
  logic [DW-1:0]   br_data = '0;
  logic            spur_ov = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_ptr = 0;
  int last_rsp_cyc = 0;
  logic [63:0] ref_mem [256];

  assign C_out_valid = br_ov | spur_ov;
  assign C_data_r    = br_data;

  bridge_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_r_wb    (req_r_wb),
    .req_addr    (req_addr),
    .req_data_w  (req_data_w),
    .req_grant   (req_grant),
    .rsp_valid   (rsp_valid),
    .rsp_data_r  (rsp_data_r),
    .busy        (busy),
    .proto_err   (proto_err),
    .C_in_valid  (C_in_valid),
    .C_r_wb      (C_r_wb),
    .C_addr      (C_addr),
    .C_data_w    (C_data_w),
    .C_out_valid (C_out_valid),
    .C_data_r    (C_data_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_word(input int i);
    if (i == 8'h12) return 64'hDEAD_BEEF_0123_4567;
    return 64'h0123_0000_0000_0000 ^ (64'(i) * 64'h0001_0001_0001_0001);
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  // Reference arbitration: first pending requester at or after the pointer, cyclically.
  function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bridge + DRAM model: accepts a command, checks it stays stable, answers after 1..20 cycles.
  initial begin : bridge_model
    logic [63:0] dram [256];
    logic [AW-1:0] cmd_a;
    logic          cmd_rw;
    logic [DW-1:0] cmd_d;
    int lat, n;
    bit aborted;
    for (int i = 0; i < 256; i++) dram[i] = init_word(i);
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && C_in_valid) begin
        cmd_a = C_addr; cmd_rw = C_r_wb; cmd_d = C_data_w;
        lat = $urandom_range(20, 1);
        n = 0; aborted = 0;
        while (n < lat && !aborted) begin
          @(posedge clk);
          #1;
          if (!rst_n) aborted = 1;
          else begin
            chk("hold_addr", C_addr, cmd_a);
            chk("hold_r_wb", C_r_wb, cmd_rw);
            chk("hold_data_w", C_data_w, cmd_d);
            n++;
          end
        end
        if (!aborted) begin
          if (cmd_rw) br_data = dram[cmd_a];
          else begin
            dram[cmd_a] = cmd_d;
            br_data = ~cmd_d;
          end
          br_ov = 1'b1;
          @(posedge clk);
          #1;
          br_ov = 1'b0;
          br_data = '0;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_r_wb[i] = rw;
    req_addr[i*AW +: AW] = a;
    req_data_w[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic check_quiet(input logic exp_perr);
    chk("q_grant", req_grant, 0);
    chk("q_rsp_valid", rsp_valid, 0);
    chk("q_rsp_data", rsp_data_r, 0);
    chk("q_busy", busy, 0);
    chk("q_c_in_valid", C_in_valid, 0);
    chk("q_c_r_wb", C_r_wb, 0);
    chk("q_c_addr", C_addr, 0);
    chk("q_c_data_w", C_data_w, 0);
    chk("q_proto_err", proto_err, exp_perr);
  endtask

  // Serves n_txn transactions from the currently pending requests, checking each against the model.
  task automatic service(input int n_txn, input bit keep, output int first_lat, output logic [63:0] last_data);
    int exp_id, lat;
    logic [AW-1:0] ea;
    logic erw;
    logic [DW-1:0] ed, exp_r;
    first_lat = 0;
    last_data = '0;
    for (int t = 0; t < n_txn; t++) begin
      exp_id = rr_pick(req_valid, exp_ptr);
      ea  = req_addr[exp_id*AW +: AW];
      erw = req_r_wb[exp_id];
      ed  = req_data_w[exp_id*DW +: DW];
      lat = 0;
      do begin @(negedge clk); lat++; end while (req_grant == '0 && lat < 200);
      if (t == 0) first_lat = lat;
      chk("grant", req_grant, onehot(exp_id));
      chk("c_in_valid", C_in_valid, 1);
      chk("c_addr", C_addr, ea);
      chk("c_r_wb", C_r_wb, erw);
      chk("c_data_w", C_data_w, ed);
      if (keep && t > 0) chk("rsp_to_grant", 64'(cyc - last_rsp_cyc), 2);
      exp_ptr = (exp_id + 1) % N;
      exp_r = erw ? ref_mem[ea] : '0;
      if (!erw) ref_mem[ea] = ed;
      if (!keep) req_valid[exp_id] = 1'b0;
      lat = 0;
      do begin
        @(negedge clk); lat++;
        if (rsp_valid == '0) chk("wait_in_valid", C_in_valid, 0);
      end while (rsp_valid == '0 && lat < 200);
      last_rsp_cyc = cyc;
      chk("rsp_valid", rsp_valid, onehot(exp_id));
      chk("rsp_data", rsp_data_r, exp_r);
      chk("resp_busy", busy, 1);
      last_data = rsp_data_r;
      $display("txn req%0d %s addr=%02h wdata=%016h rdata=%016h", exp_id, erw ? "RD" : "WR", ea, ed, rsp_data_r);
      @(negedge clk);
      chk("rsp_data_clr", rsp_data_r, 0);
      chk("rsp_valid_clr", rsp_valid, 0);
      chk("idle_busy", busy, 0);
    end
    if (keep) req_valid = '0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, cnt, mask;
    logic [63:0] d;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset, then 10 idle cycles.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
    repeat (10) @(negedge clk);
    check_quiet(1'b0);

    // Both requesters held high from reset: strict alternation, minimum spacing.
    set_req(0, 1'b1, 8'h21, 64'h0);
    set_req(1, 1'b1, 8'h34, 64'h0);
    service(6, 1'b1, lat, d);
    chk("rr_first_lat", lat, 1);

    // Single read of the preloaded word.
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 8'h12, 64'h0);
    service(1, 1'b0, lat, d);
    chk("req_to_grant", lat, 1);
    chk("rd_12", d, 64'hDEAD_BEEF_0123_4567);

    // Write from requester 1, read back from requester 0.
    set_req(1, 1'b0, 8'h05, 64'h1111_2222_3333_4444);
    service(1, 1'b0, lat, d);
    chk("wr_05_rsp", d, 0);
    set_req(0, 1'b1, 8'h05, 64'h0);
    service(1, 1'b0, lat, d);
    chk("rd_05", d, 64'h1111_2222_3333_4444);

    // Spurious completion strobe while idle.
    repeat (2) @(negedge clk);
    spur_ov = 1'b1;
    @(negedge clk);
    spur_ov = 1'b0;
    chk("spur_proto_err", proto_err, 1);
    chk("spur_rsp_valid", rsp_valid, 0);
    chk("spur_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("spur_sticky", proto_err, 1);
    set_req(1, 1'b1, 8'h77, 64'h0);
    service(1, 1'b0, lat, d);
    chk("after_spur_proto_err", proto_err, 1);

    // Random request subsets and payloads.
    for (int r = 0; r < 12; r++) begin
      mask = $urandom_range((1 << N) - 1, 1);
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          set_req(i, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), {$urandom, $urandom});
          cnt++;
        end
      end
      service(cnt, 1'b0, lat, d);
    end

    // Asynchronous reset while waiting on the bridge.
    set_req(0, 1'b1, 8'h40, 64'h0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (req_grant == '0 && lat < 200);
    chk("t6_grant", req_grant, onehot(rr_pick(2'b01, exp_ptr)));
    req_valid = '0;
    @(negedge clk);
    chk("t6_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check_quiet(1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
    @(negedge clk);
    check_quiet(1'b0);
    set_req(0, 1'b1, 8'hFF, 64'h0);
    service(1, 1'b0, lat, d);
    chk("rd_ff", d, init_word(255));

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
